// File: rtl/dac_lane_aligner_pkg.sv
// Shared types and constants for the DAC lane aligner: FSM state encoding, lane entry layout, widths.
// No logic here, so no latency or backpressure of its own.
package dac_lane_aligner_pkg;

    localparam int LANES_DEF   = 8;
    localparam int SAMPLE_W    = 16;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } align_state_e;

    typedef struct packed {
        logic [SAMPLE_W-1:0] i;
        logic [SAMPLE_W-1:0] q;
        logic                last;
    } lane_entry_t;

    // Occupancy counter must also represent the full value DEPTH.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dac_lane_aligner_if.sv
// Per-lane I/Q sample streams into the aligner and lane-aligned DAC words out of it.
// Streams carry valid only; the source is always ready, so no ready signal exists.
interface dac_lane_aligner_if
    import dac_lane_aligner_pkg::*;
#(
    parameter int LANES = LANES_DEF
) ();

    logic [LANES-1:0]               s_axis_I_tvalid;
    logic [LANES-1:0]               s_axis_I_tlast;
    logic [LANES-1:0][SAMPLE_W-1:0] s_axis_I_tdata;
    logic [LANES-1:0]               s_axis_Q_tvalid;
    logic [LANES-1:0]               s_axis_Q_tlast;
    logic [LANES-1:0][SAMPLE_W-1:0] s_axis_Q_tdata;

    logic [LANES-1:0][SAMPLE_W-1:0] dac_I_data;
    logic [LANES-1:0][SAMPLE_W-1:0] dac_Q_data;
    logic                           dac_valid;

    modport master (
        output s_axis_I_tvalid, s_axis_I_tlast, s_axis_I_tdata,
        output s_axis_Q_tvalid, s_axis_Q_tlast, s_axis_Q_tdata,
        input  dac_I_data, dac_Q_data, dac_valid
    );

    modport slave (
        input  s_axis_I_tvalid, s_axis_I_tlast, s_axis_I_tdata,
        input  s_axis_Q_tvalid, s_axis_Q_tlast, s_axis_Q_tdata,
        output dac_I_data, dac_Q_data, dac_valid
    );

endinterface

// File: rtl/dac_lane_aligner_lane_fifo.sv
// Single-lane synchronous FIFO of I/Q entries; read data is combinational from the head (0-cycle read).
// No backpressure: a push on full is dropped unless a pop frees the slot in the same cycle.
module lane_fifo
    import dac_lane_aligner_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        core_clk,
    input  logic                        arst_n,
    input  logic                        push_vld,
    input  lane_entry_t                 push_dat,
    input  logic                        pop_vld,
    output lane_entry_t                 pop_dat,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    lane_entry_t    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;
    logic           do_push;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop_vld & ~empty;
    assign do_push = push_vld & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/dac_lane_aligner.sv
// Buffers LANES I/Q streams and releases them in lockstep to the DACs; output registered 1 cycle after the common pop.
// Upstream is never back-pressured: misaligned, full-lane and starved cycles are dropped or idled and flagged.
module dac_lane_aligner
    import dac_lane_aligner_pkg::*;
#(
    parameter int                  LANES     = LANES_DEF,
    parameter int                  DEPTH     = 16,
    parameter int                  PRIME     = 4,
    parameter logic [SAMPLE_W-1:0] IDLE_CODE = 16'h0000
) (
    input  logic                   clk_250m,
    input  logic                   reset,
    dac_lane_aligner_if.slave      bus,
    input  logic                   clear_flags,
    output logic                   frame_active,
    output logic                   underflow,
    output logic                   overflow,
    output logic                   iq_misalign,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int         CNT_W    = cnt_width(DEPTH);
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_FILL   = ST_FILL;
    localparam logic [1:0] S_STREAM = ST_STREAM;

    logic [1:0]                  state;
    logic [1:0]                  state_nxt;
    logic [LANES-1:0]            lane_wr_vld;
    logic [LANES-1:0]            lane_full;
    logic [LANES-1:0]            lane_empty;
    logic [LANES-1:0]            pop_last;
    logic [LANES-1:0][CNT_W-1:0] lane_count;
    lane_entry_t                 pop_dat [LANES];
    logic                        all_primed;
    logic                        pop_vld;
    logic                        frame_end;
    logic                        underflow_ev;
    logic                        overflow_ev;
    logic                        misalign_ev;
    logic                        unused_last;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_entry_t push_dat;

        assign push_dat       = '{i: bus.s_axis_I_tdata[l], q: bus.s_axis_Q_tdata[l], last: bus.s_axis_I_tlast[l]};
        assign lane_wr_vld[l] = bus.s_axis_I_tvalid[l] & bus.s_axis_Q_tvalid[l];
        assign pop_last[l]    = pop_dat[l].last;

        lane_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .core_clk (clk_250m),
            .arst_n   (reset),
            .push_vld (lane_wr_vld[l]),
            .push_dat (push_dat),
            .pop_vld  (pop_vld),
            .pop_dat  (pop_dat[l]),
            .count    (lane_count[l]),
            .full     (lane_full[l]),
            .empty    (lane_empty[l])
        );
    end

    always_comb begin
        all_primed = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            if (lane_count[l] < CNT_W'(PRIME)) all_primed = 1'b0;
        end
    end

    // All lanes pop as one; a single empty lane stalls every lane.
    assign pop_vld      = (state == S_STREAM) & ~|lane_empty;
    assign underflow_ev = (state == S_STREAM) &  |lane_empty;
    assign frame_end    = pop_vld & pop_last[0];
    assign overflow_ev  = |(lane_wr_vld & lane_full & ~{LANES{pop_vld}});
    assign misalign_ev  = |(bus.s_axis_I_tvalid ^ bus.s_axis_Q_tvalid);

    // Frame boundaries follow lane 0 only; other tlast bits and Q tlast carry no meaning here.
    assign unused_last  = ^{pop_last, bus.s_axis_Q_tlast};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (~&lane_empty) state_nxt = S_FILL;
            S_FILL:   if (all_primed)   state_nxt = S_STREAM;
            S_STREAM: begin
                if (underflow_ev)   state_nxt = S_FILL;
                else if (frame_end) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_250m or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            frame_active <= 1'b0;
            underflow    <= 1'b0;
            overflow     <= 1'b0;
            iq_misalign  <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_nxt;
            frame_active <= (state_nxt != S_IDLE);
            // A set event in the same cycle as a clear wins.
            underflow    <= (underflow   & ~clear_flags) | underflow_ev;
            overflow     <= (overflow    & ~clear_flags) | overflow_ev;
            iq_misalign  <= (iq_misalign & ~clear_flags) | misalign_ev;
            if (frame_end) frame_count <= frame_count + 1'b1;
        end
    end

    always_ff @(posedge clk_250m or negedge reset) begin
        if (!reset) begin
            bus.dac_valid  <= 1'b0;
            bus.dac_I_data <= {LANES{IDLE_CODE}};
            bus.dac_Q_data <= {LANES{IDLE_CODE}};
        end else begin
            bus.dac_valid <= pop_vld;
            for (int l = 0; l < LANES; l++) begin
                bus.dac_I_data[l] <= pop_vld ? pop_dat[l].i : IDLE_CODE;
                bus.dac_Q_data[l] <= pop_vld ? pop_dat[l].q : IDLE_CODE;
            end
        end
    end

endmodule

// File: tb/tb_dac_lane_aligner.sv
// Scenario bench for dac_lane_aligner against a queue-based reference model of the lane rules.
module tb_dac_lane_aligner;
    import dac_lane_aligner_pkg::*;

    localparam int          L    = 8;
    localparam int          D    = 16;
    localparam int          P    = 4;
    localparam logic [15:0] IDLE = 16'h8000;
    localparam int          VW   = 21 + 2 * L * 16;

    logic        clk         = 1'b0;
    logic        reset       = 1'b1;
    logic        clear_flags = 1'b0;
    logic        frame_active, underflow, overflow, iq_misalign;
    logic [15:0] frame_count;

    dac_lane_aligner_if #(.LANES(L)) bus ();

    dac_lane_aligner #(
        .LANES     (L),
        .DEPTH     (D),
        .PRIME     (P),
        .IDLE_CODE (IDLE)
    ) dut (
        .clk_250m     (clk),
        .reset        (reset),
        .bus          (bus),
        .clear_flags  (clear_flags),
        .frame_active (frame_active),
        .underflow    (underflow),
        .overflow     (overflow),
        .iq_misalign  (iq_misalign),
        .frame_count  (frame_count)
    );

    always #2 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: one queue per lane plus the abstract aligner mode.
    lane_entry_t        mq [L][$];
    int                 m_mode;
    logic               m_valid, m_active, m_under, m_over, m_mis;
    logic [15:0]        m_fc;
    logic [L-1:0][15:0] m_i, m_q;

    int checks = 0;
    int passes = 0;
    int sch_start [L];
    int sch_cnt   [L];
    int sch_last  [L];

    function automatic logic [VW-1:0] dut_vec();
        return {bus.dac_valid, frame_active, underflow, overflow, iq_misalign, frame_count,
                bus.dac_I_data, bus.dac_Q_data};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        return {m_valid, m_active, m_under, m_over, m_mis, m_fc, m_i, m_q};
    endfunction

    function automatic logic [VW-1:0] reset_vec();
        logic [L-1:0][15:0] idle_words;
        idle_words = {L{IDLE}};
        return {5'b0, 16'h0, idle_words, idle_words};
    endfunction

    task automatic model_reset();
        for (int l = 0; l < L; l++) mq[l].delete();
        m_mode = 0; m_valid = 0; m_active = 0;
        m_under = 0; m_over = 0; m_mis = 0; m_fc = 16'h0;
        m_i = {L{IDLE}}; m_q = {L{IDLE}};
    endtask

    // Mode 0 = waiting, 1 = priming, 2 = streaming.
    task automatic model_step();
        bit          ok, und, ovf, mis, fend;
        int          nmode;
        lane_entry_t e;
        nmode = m_mode; und = 0; ovf = 0; mis = 0; fend = 0;
        m_valid = 0; m_i = {L{IDLE}}; m_q = {L{IDLE}};
        if (m_mode == 0) begin
            for (int l = 0; l < L; l++) if (mq[l].size() > 0) nmode = 1;
        end else if (m_mode == 1) begin
            ok = 1;
            for (int l = 0; l < L; l++) if (mq[l].size() < P) ok = 0;
            if (ok) nmode = 2;
        end else begin
            ok = 1;
            for (int l = 0; l < L; l++) if (mq[l].size() == 0) ok = 0;
            if (!ok) begin
                und = 1; nmode = 1;
            end else begin
                m_valid = 1;
                for (int l = 0; l < L; l++) begin
                    e = mq[l].pop_front();
                    m_i[l] = e.i; m_q[l] = e.q;
                    if (l == 0 && e.last) fend = 1;
                end
                if (fend) begin m_fc = m_fc + 16'd1; nmode = 0; end
            end
        end
        for (int l = 0; l < L; l++) begin
            if (bus.s_axis_I_tvalid[l] && bus.s_axis_Q_tvalid[l]) begin
                e = '{i: bus.s_axis_I_tdata[l], q: bus.s_axis_Q_tdata[l], last: bus.s_axis_I_tlast[l]};
                if (mq[l].size() < D) mq[l].push_back(e);
                else ovf = 1;
            end else if (bus.s_axis_I_tvalid[l] != bus.s_axis_Q_tvalid[l]) begin
                mis = 1;
            end
        end
        m_under = (m_under && !clear_flags) || und;
        m_over  = (m_over  && !clear_flags) || ovf;
        m_mis   = (m_mis   && !clear_flags) || mis;
        m_mode  = nmode;
        m_active = (nmode != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        bus.s_axis_I_tvalid = '0; bus.s_axis_Q_tvalid = '0;
        bus.s_axis_I_tlast  = '0; bus.s_axis_Q_tlast  = '0;
        bus.s_axis_I_tdata  = '0; bus.s_axis_Q_tdata  = '0;
    endtask

    task automatic sched_all(input int cnt, input int last_idx);
        for (int l = 0; l < L; l++) begin
            sch_start[l] = 0; sch_cnt[l] = cnt; sch_last[l] = last_idx;
        end
    endtask

    // Lane l sends sample n at cycle start+n with I = l*16+n; only lane 0 tlast is meaningful.
    task automatic drive_sched(input int c);
        int n;
        drive_idle();
        for (int l = 0; l < L; l++) begin
            n = c - sch_start[l];
            if (n >= 0 && n < sch_cnt[l]) begin
                bus.s_axis_I_tvalid[l] = 1'b1;
                bus.s_axis_Q_tvalid[l] = 1'b1;
                bus.s_axis_I_tdata[l]  = 16'(l * 16 + n);
                bus.s_axis_Q_tdata[l]  = 16'($urandom);
                bus.s_axis_I_tlast[l]  = (l == 0) ? (n == sch_last[l]) : 1'($urandom);
                bus.s_axis_Q_tlast[l]  = 1'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        drive_idle();
        clear_flags = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        #1 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== reset_vec()) $display("FAIL reset_async dut=%h exp=%h", dut_vec(), reset_vec());
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== reset_vec()) $display("FAIL reset_held dut=%h exp=%h", dut_vec(), reset_vec());
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++;
        if (dut_vec() !== model_vec()) $display("FAIL reset_release dut=%h exp=%h", dut_vec(), model_vec());
        else passes++;
    endtask

    task automatic test_aligned_frame();
        int nv = 0, first_v = -1, last_v = -1;
        do_reset();
        sched_all(6, 5);
        for (int c = 0; c < 16; c++) begin
            drive_sched(c);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL aligned c=%0d dut=%h exp=%h", c, dut_vec(), model_vec());
            else passes++;
            if (bus.dac_valid === 1'b1) begin
                nv++; last_v = c;
                if (first_v < 0) first_v = c;
            end
        end
        checks++;
        if (nv != 6 || last_v - first_v != 5)
            $display("FAIL aligned_run valid_cycles=%0d span=%0d expected 6 contiguous", nv, last_v - first_v + 1);
        else passes++;
        checks++;
        if (frame_count !== 16'd1 || frame_active !== 1'b0)
            $display("FAIL aligned_end frame_count=%0d active=%b expected 1/0", frame_count, frame_active);
        else passes++;
    endtask

    task automatic test_skew();
        int                 first_v = -1;
        logic [L-1:0][15:0] first_i, exp_i;
        do_reset();
        sched_all(6, 5);
        sch_start[7] = 3;
        for (int l = 0; l < L; l++) exp_i[l] = 16'(l * 16);
        first_i = '0;
        for (int c = 0; c < 20; c++) begin
            drive_sched(c);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL skew c=%0d dut=%h exp=%h", c, dut_vec(), model_vec());
            else passes++;
            if (bus.dac_valid === 1'b1 && first_v < 0) begin
                first_v = c; first_i = bus.dac_I_data;
            end
        end
        // Lane 7 holds 4 entries after cycle 6, streaming begins at 7, first pop lands at 8.
        checks++;
        if (first_v != 8 || first_i !== exp_i)
            $display("FAIL skew_first cycle=%0d data=%h expected cycle 8 data=%h", first_v, first_i, exp_i);
        else passes++;
    endtask

    task automatic test_starvation();
        do_reset();
        sched_all(10, 9);
        sch_cnt[3] = 5;
        for (int c = 0; c < 14; c++) begin
            drive_sched(c);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL starve c=%0d dut=%h exp=%h", c, dut_vec(), model_vec());
            else passes++;
        end
        checks++;
        if (underflow !== 1'b1 || bus.dac_valid !== 1'b0 || frame_active !== 1'b1 || bus.dac_I_data[0] !== IDLE)
            $display("FAIL starve_state uf=%b valid=%b active=%b d0=%h expected 1/0/1/%h",
                     underflow, bus.dac_valid, frame_active, bus.dac_I_data[0], IDLE);
        else passes++;
        drive_idle();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        checks++;
        if (underflow !== 1'b0 || dut_vec() !== model_vec())
            $display("FAIL starve_clear uf=%b dut=%h exp=%h", underflow, dut_vec(), model_vec());
        else passes++;
    endtask

    task automatic test_overflow();
        int          nv = 0;
        logic [15:0] last_lane0 = 16'hFFFF;
        do_reset();
        for (int l = 0; l < L; l++) begin
            sch_start[l] = (l == 0) ? 0 : 17;
            sch_cnt[l]   = (l == 0) ? 17 : 16;
            sch_last[l]  = 15;
        end
        for (int c = 0; c < 45; c++) begin
            drive_sched(c);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL overflow c=%0d dut=%h exp=%h", c, dut_vec(), model_vec());
            else passes++;
            if (bus.dac_valid === 1'b1) begin
                nv++; last_lane0 = bus.dac_I_data[0];
            end
        end
        checks++;
        if (overflow !== 1'b1 || nv != 16 || last_lane0 !== 16'd15)
            $display("FAIL overflow_result flag=%b pops=%0d last_lane0=%0d expected 1/16/15", overflow, nv, last_lane0);
        else passes++;
    endtask

    task automatic test_misalign();
        do_reset();
        drive_idle();
        bus.s_axis_I_tvalid[2] = 1'b1;
        bus.s_axis_I_tdata[2]  = 16'($urandom);
        tick();
        drive_idle();
        repeat (3) tick();
        checks++;
        if (iq_misalign !== 1'b1 || frame_active !== 1'b0 || dut_vec() !== model_vec())
            $display("FAIL misalign mis=%b active=%b dut=%h exp=%h", iq_misalign, frame_active, dut_vec(), model_vec());
        else passes++;
        bus.s_axis_Q_tvalid[2] = 1'b1;
        clear_flags = 1'b1;
        tick();
        drive_idle();
        checks++;
        if (iq_misalign !== 1'b1) $display("FAIL misalign_clear_collide mis=%b expected 1", iq_misalign);
        else passes++;
        tick();
        clear_flags = 1'b0;
        checks++;
        if (iq_misalign !== 1'b0 || dut_vec() !== model_vec())
            $display("FAIL misalign_clear mis=%b dut=%h exp=%h", iq_misalign, dut_vec(), model_vec());
        else passes++;
    endtask

    task automatic test_reset_mid_stream();
        bit found = 0;
        int nv = 0;
        do_reset();
        sched_all(6, 5);
        for (int c = 0; c < 30 && !found; c++) begin
            drive_sched(c);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL midreset_pre c=%0d dut=%h exp=%h", c, dut_vec(), model_vec());
            else passes++;
            if (bus.dac_valid === 1'b1 && bus.dac_I_data[0] === 16'd3) found = 1;
        end
        checks++;
        if (!found) $display("FAIL midreset_reach sample 3 never seen within 30 cycles");
        else passes++;
        #1 reset = 1'b0;
        drive_idle();
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== reset_vec()) $display("FAIL midreset_async dut=%h exp=%h", dut_vec(), reset_vec());
        else passes++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 16; c++) begin
            drive_sched(c);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL midreset_post c=%0d dut=%h exp=%h", c, dut_vec(), model_vec());
            else passes++;
            if (bus.dac_valid === 1'b1) nv++;
        end
        checks++;
        if (frame_count !== 16'd1 || nv != 6)
            $display("FAIL midreset_frame frame_count=%0d pops=%0d expected 1/6", frame_count, nv);
        else passes++;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            drive_idle();
            clear_flags = ($urandom_range(0, 19) == 0);
            for (int l = 0; l < L; l++) begin
                r = $urandom_range(0, 99);
                bus.s_axis_I_tvalid[l] = (r < 87);
                bus.s_axis_Q_tvalid[l] = (r < 85) || (r >= 87 && r < 89);
                bus.s_axis_I_tdata[l]  = 16'($urandom);
                bus.s_axis_Q_tdata[l]  = 16'($urandom);
                bus.s_axis_I_tlast[l]  = (l == 0) ? ($urandom_range(0, 11) == 0) : 1'($urandom);
                bus.s_axis_Q_tlast[l]  = 1'($urandom);
            end
            tick();
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL random c=%0d dut=%h exp=%h", c, dut_vec(), model_vec());
            else passes++;
        end
        clear_flags = 1'b0;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_aligned_frame();
        test_skew();
        test_starvation();
        test_overflow();
        test_misalign();
        test_reset_mid_stream();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
